// File: rtl/syn_wm8731_i2c_cfg.sv
// syn_wm8731_i2c_cfg: local-bus programmed I2C write master that loads one
// WM8731 control register per transaction (dev addr, {reg, d[8]}, d[7:0]).
module syn_wm8731_i2c_cfg #(
  parameter int unsigned P_LB_DATA_W = 16,
  parameter int unsigned P_LB_ADDR_W = 8,
  parameter int unsigned P_QTR_DIV   = 125,
  parameter logic [6:0]  P_DEV_ADDR  = 7'h1A,
  parameter logic [7:0]  P_CTRL_ADDR = 8'h20,
  parameter logic [7:0]  P_CFG_ADDR  = 8'h21
) (
  input  logic                   clk_ir,
  input  logic                   rst_sync_l,
  input  logic                   lb_wr_en,
  input  logic                   lb_rd_en,
  input  logic [P_LB_ADDR_W-1:0] lb_addr,
  input  logic [P_LB_DATA_W-1:0] lb_wr_data,
  output logic                   lb_wr_valid,
  output logic                   lb_rd_valid,
  output logic [P_LB_DATA_W-1:0] lb_rd_data,
  output logic                   scl,
  output logic                   sda_o,
  output logic                   sda_oe,
  input  logic                   sda_i
);

  localparam int unsigned LP_CNT_W = 10;
  localparam int unsigned LP_CFG_W = 16;

  typedef enum logic [2:0] {
    IDLE_S,
    START_S,
    BYTE_S,
    ACK_S,
    STOP_S
  } state_t;

  state_t              r_state;
  logic [LP_CNT_W-1:0] r_qtr_cntr;
  logic [1:0]          r_phase;
  logic [1:0]          r_byte_idx;
  logic [2:0]          r_bit_idx;
  logic                r_busy;
  logic                r_nack;
  logic                r_ack_smp;
  logic [LP_CFG_W-1:0] r_cfg_data;

  logic       w_qtr_tck;
  logic       w_ctrl_sel;
  logic       w_cfg_sel;
  logic       w_start;
  logic       w_cfg_wr;
  logic [7:0] w_cur_byte;
  logic       w_cur_bit;
  logic       w_scl;
  logic       w_sda_oe;

  assign w_ctrl_sel = (lb_addr == P_LB_ADDR_W'(P_CTRL_ADDR));
  assign w_cfg_sel  = (lb_addr == P_LB_ADDR_W'(P_CFG_ADDR));
  assign w_start    = lb_wr_en && w_ctrl_sel && lb_wr_data[0] && !r_busy;
  assign w_cfg_wr   = lb_wr_en && w_cfg_sel && !r_busy;
  assign w_qtr_tck  = (r_state != IDLE_S) &&
                      (r_qtr_cntr == LP_CNT_W'(P_QTR_DIV - 1));
  assign sda_o      = 1'b0;

  // Byte currently on the wire and the bit selected from it (MSB first)
  always_comb begin
    w_cur_byte = r_cfg_data[7:0];
    case (r_byte_idx)
      2'd0:    w_cur_byte = {P_DEV_ADDR, 1'b0};
      2'd1:    w_cur_byte = r_cfg_data[15:8];
      default: w_cur_byte = r_cfg_data[7:0];
    endcase
    w_cur_bit = w_cur_byte[r_bit_idx];
  end

  // Local-bus register file, acknowledges and read mux
  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      lb_wr_valid <= 1'b0;
      lb_rd_valid <= 1'b0;
      lb_rd_data  <= '0;
      r_cfg_data  <= '0;
    end else begin
      lb_wr_valid <= lb_wr_en;
      lb_rd_valid <= lb_rd_en;
      if (w_cfg_wr) begin
        r_cfg_data <= lb_wr_data[LP_CFG_W-1:0];
      end
      if (lb_rd_en) begin
        if (w_cfg_sel) begin
          lb_rd_data <= P_LB_DATA_W'(r_cfg_data);
        end else if (w_ctrl_sel) begin
          lb_rd_data <= P_LB_DATA_W'({r_nack, r_busy});
        end else begin
          lb_rd_data <= P_LB_DATA_W'(16'hdead);
        end
      end
    end
  end

  // Transaction FSM with quarter-period timebase and bit/byte sequencing
  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      r_state    <= IDLE_S;
      r_qtr_cntr <= '0;
      r_phase    <= 2'd0;
      r_byte_idx <= 2'd0;
      r_bit_idx  <= 3'd7;
      r_busy     <= 1'b0;
      r_nack     <= 1'b0;
      r_ack_smp  <= 1'b0;
    end else begin
      if (r_state == IDLE_S || w_qtr_tck) begin
        r_qtr_cntr <= '0;
      end else begin
        r_qtr_cntr <= r_qtr_cntr + LP_CNT_W'(1);
      end
      if (w_qtr_tck) begin
        r_phase <= r_phase + 2'd1;
      end

      case (r_state)
        IDLE_S: begin
          if (w_start) begin
            r_state <= START_S;
            r_phase <= 2'd0;
            r_busy  <= 1'b1;
            r_nack  <= 1'b0;
          end
        end
        START_S: begin
          if (w_qtr_tck && r_phase == 2'd3) begin
            r_state    <= BYTE_S;
            r_phase    <= 2'd0;
            r_byte_idx <= 2'd0;
            r_bit_idx  <= 3'd7;
          end
        end
        BYTE_S: begin
          if (w_qtr_tck && r_phase == 2'd3) begin
            r_phase <= 2'd0;
            if (r_bit_idx == 3'd0) begin
              r_state <= ACK_S;
            end else begin
              r_bit_idx <= r_bit_idx - 3'd1;
            end
          end
        end
        ACK_S: begin
          if (w_qtr_tck && r_phase == 2'd2) begin
            r_ack_smp <= sda_i;
          end
          if (w_qtr_tck && r_phase == 2'd3) begin
            r_phase <= 2'd0;
            if (r_ack_smp) begin
              r_nack  <= 1'b1;
              r_state <= STOP_S;
            end else if (r_byte_idx != 2'd2) begin
              r_byte_idx <= r_byte_idx + 2'd1;
              r_bit_idx  <= 3'd7;
              r_state    <= BYTE_S;
            end else begin
              r_state <= STOP_S;
            end
          end
        end
        STOP_S: begin
          if (w_qtr_tck && r_phase == 2'd3) begin
            r_state <= IDLE_S;
            r_phase <= 2'd0;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE_S;
      endcase
    end
  end

  // Line levels per state and phase; released/high when idle
  always_comb begin
    w_scl    = 1'b1;
    w_sda_oe = 1'b0;
    case (r_state)
      START_S: begin
        w_scl    = (r_phase != 2'd3);
        w_sda_oe = r_phase[1];
      end
      BYTE_S: begin
        w_scl    = r_phase[1];
        w_sda_oe = ~w_cur_bit;
      end
      ACK_S: begin
        w_scl    = r_phase[1];
        w_sda_oe = 1'b0;
      end
      STOP_S: begin
        w_scl    = (r_phase != 2'd0);
        w_sda_oe = ~r_phase[1];
      end
      default: begin
        w_scl    = 1'b1;
        w_sda_oe = 1'b0;
      end
    endcase
  end

  // Register the I2C pins; reset releases the bus immediately
  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      scl    <= 1'b1;
      sda_oe <= 1'b0;
    end else begin
      scl    <= w_scl;
      sda_oe <= w_sda_oe;
    end
  end

endmodule

// File: tb/tb_syn_wm8731_i2c_cfg.sv
// tb_syn_wm8731_i2c_cfg: bus-level bench with an I2C slave/decoder on the pins.
module tb_syn_wm8731_i2c_cfg;

  localparam int unsigned Q    = 4;
  localparam logic [7:0]  CTRL = 8'h20;
  localparam logic [7:0]  CFG  = 8'h21;

  typedef struct {
    logic [15:0] cfg;
    logic [2:0]  ack;        // bit i = slave acks byte i
    logic [15:0] exp_status;
    int          exp_n;      // bytes that appear on the wire
    logic [23:0] exp_bytes;
    int          exp_clks;   // poll index at which busy is first seen clear
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, rd_en;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic        wr_valid, rd_valid;
  logic [15:0] rdata;
  logic        scl, sda_o, sda_oe, sda_i;
  logic        slave_pull;

  assign sda_i = ~sda_oe & ~slave_pull;

  always #5 clk = ~clk;

  syn_wm8731_i2c_cfg #(.P_QTR_DIV(Q)) u_dut (
    .clk_ir      (clk),
    .rst_sync_l  (rst_n),
    .lb_wr_en    (wr_en),
    .lb_rd_en    (rd_en),
    .lb_addr     (addr),
    .lb_wr_data  (wdata),
    .lb_wr_valid (wr_valid),
    .lb_rd_valid (rd_valid),
    .lb_rd_data  (rdata),
    .scl         (scl),
    .sda_o       (sda_o),
    .sda_oe      (sda_oe),
    .sda_i       (sda_i)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Wire monitor and slave: decodes bytes, counts START/STOP, drives ACKs
  logic       mon_clr;
  logic [2:0] plan_ack;
  logic [7:0] mon_bytes[$];
  int         n_start, n_stop, n_glitch, bitcnt;
  logic       in_txn, p_scl, p_sda, c_scl, c_sda;
  logic [7:0] sh;

  initial begin
    forever begin
      @(negedge clk);
      c_scl = scl;
      c_sda = sda_i;
      if (!rst_n || mon_clr) begin
        bitcnt = 0; in_txn = 1'b0; mon_bytes.delete();
        n_start = 0; n_stop = 0; n_glitch = 0; slave_pull = 1'b0; sh = 8'h00;
      end else begin
        if (p_scl && c_scl && p_sda && !c_sda) begin
          n_start++; bitcnt = 0; in_txn = 1'b1;
        end else if (p_scl && c_scl && !p_sda && c_sda) begin
          n_stop++; in_txn = 1'b0;
        end else if (p_scl && c_scl && (p_sda != c_sda)) begin
          n_glitch++;
        end
        if (!p_scl && c_scl && in_txn) begin
          if (bitcnt < 8) begin
            sh = {sh[6:0], c_sda}; bitcnt++;
          end else begin
            mon_bytes.push_back(sh); bitcnt = 0;
          end
        end
        if (p_scl && !c_scl && in_txn)
          slave_pull = (bitcnt == 8) && (mon_bytes.size() < 3) && plan_ack[mon_bytes.size()];
      end
      p_scl = c_scl;
      p_sda = c_sda;
    end
  end

  task automatic mon_reset();
    @(negedge clk); mon_clr = 1'b1;
    @(negedge clk); #1 mon_clr = 1'b0;
  endtask

  task automatic lb_write(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk); addr = a; wdata = d; wr_en = 1'b1;
    @(negedge clk); wr_en = 1'b0;
    check("wr_valid", 32'(wr_valid), 32'd1);
  endtask

  task automatic lb_read(input logic [7:0] a, output logic [15:0] d);
    @(negedge clk); addr = a; rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    check("rd_valid", 32'(rd_valid), 32'd1);
    d = rdata;
  endtask

  // Poll STATUS every cycle until busy reads clear (bounded)
  task automatic wait_idle(input bit chk_first, output int k, output logic [15:0] st);
    addr = CTRL; rd_en = 1'b1; k = 0; st = 16'hffff;
    while (k < 200 * Q + 50) begin
      @(negedge clk); k++;
      st = rdata;
      if (chk_first && k == 1) check("busy_set", 32'(rdata), 32'h0001);
      if (rdata[0] == 1'b0) break;
    end
    rd_en = 1'b0;
    if (st[0] != 1'b0) check("idle_timeout", 32'(st), 32'h0);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_vec(input vec_t v);
    int k; logic [15:0] st;
    lb_write(CFG, v.cfg);
    plan_ack = v.ack;
    mon_reset();
    @(negedge clk); addr = CTRL; wdata = 16'h0001; wr_en = 1'b1;
    @(negedge clk); wr_en = 1'b0;
    check("start_wr_valid", 32'(wr_valid), 32'd1);
    wait_idle(1'b1, k, st);
    check("busy_clks", 32'(k), 32'(v.exp_clks));
    check("status", 32'(st), 32'(v.exp_status));
    check("nbytes", 32'(mon_bytes.size()), 32'(v.exp_n));
    for (int i = 0; i < v.exp_n; i++)
      if (i < mon_bytes.size())
        check($sformatf("byte%0d", i), 32'(mon_bytes[i]), 32'(v.exp_bytes[23-8*i -: 8]));
    check("n_start", 32'(n_start), 32'd1);
    check("n_stop", 32'(n_stop), 32'd1);
    check("sda_glitch", 32'(n_glitch), 32'd0);
    check("sda_o", 32'(sda_o), 32'd0);
  endtask

  // Reference model: expected result computed from the protocol rules
  function automatic vec_t model(input logic [15:0] cfg, input logic [2:0] ack);
    vec_t v;
    v.cfg        = cfg;
    v.ack        = ack;
    v.exp_n      = !ack[0] ? 1 : (!ack[1] ? 2 : 3);
    v.exp_status = (&ack) ? 16'h0000 : 16'h0002;
    v.exp_bytes  = {8'h34, cfg};
    v.exp_clks   = 4 * Q * (2 + 9 * v.exp_n) + 1;
    return v;
  endfunction

  vec_t        tbl[6];
  logic [15:0] d;
  int          k;

  initial begin
    tbl[0] = '{16'h1E00, 3'b111, 16'h0000, 3, 24'h341E00, 465};
    tbl[1] = '{16'h0E42, 3'b111, 16'h0000, 3, 24'h340E42, 465};
    tbl[2] = '{16'h1234, 3'b110, 16'h0002, 1, 24'h341234, 177};
    tbl[3] = '{16'h0C9F, 3'b111, 16'h0000, 3, 24'h340C9F, 465};
    tbl[4] = '{16'hABCD, 3'b101, 16'h0002, 2, 24'h34ABCD, 321};
    tbl[5] = '{16'h55AA, 3'b011, 16'h0002, 3, 24'h3455AA, 465};

    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = 8'h00; wdata = 16'h0000;
    mon_clr = 1'b0; plan_ack = 3'b111;
    repeat (3) @(negedge clk);
    check("rst_scl", 32'(scl), 32'd1);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rdata), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    lb_read(CTRL, d); check("status_rst", 32'(d), 32'h0);
    lb_read(CFG, d);  check("cfg_rst", 32'(d), 32'h0);

    // Unmapped read: data and one-cycle valid
    @(negedge clk); addr = 8'h05; rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    check("unmap_valid", 32'(rd_valid), 32'd1);
    check("unmap_data", 32'(rdata), 32'hdead);
    @(negedge clk);
    check("unmap_valid_drop", 32'(rd_valid), 32'd0);

    for (int i = 0; i < 6; i++) do_vec(tbl[i]);

    // Writes while busy are acknowledged but ignored
    lb_write(CFG, 16'h3C81);
    plan_ack = 3'b111;
    mon_reset();
    lb_write(CTRL, 16'h0001);
    repeat (30) @(negedge clk);
    lb_write(CFG, 16'hFFFF);
    lb_write(CTRL, 16'h0001);
    wait_idle(1'b0, k, d);
    check("busy_status", 32'(d), 32'h0);
    check("busy_nbytes", 32'(mon_bytes.size()), 32'd3);
    if (mon_bytes.size() == 3) begin
      check("busy_b0", 32'(mon_bytes[0]), 32'h34);
      check("busy_b1", 32'(mon_bytes[1]), 32'h3C);
      check("busy_b2", 32'(mon_bytes[2]), 32'h81);
    end
    check("busy_n_start", 32'(n_start), 32'd1);
    lb_read(CFG, d); check("busy_cfg_kept", 32'(d), 32'h3C81);

    // Reset in the middle of byte 0 releases the bus asynchronously
    lb_write(CFG, 16'h0E42);
    mon_reset();
    lb_write(CTRL, 16'h0001);
    k = 0;
    while (scl != 1'b0 && k < 200) begin @(negedge clk); k++; end
    while (scl != 1'b1 && k < 200) begin @(negedge clk); k++; end
    while (!(scl == 1'b0 && sda_oe == 1'b1) && k < 200) begin @(negedge clk); k++; end
    check("mid_byte_pre", 32'({scl, sda_oe}), 32'b01);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_scl", 32'(scl), 32'd1);
    check("mid_rst_sda_oe", 32'(sda_oe), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    lb_read(CTRL, d); check("mid_rst_status", 32'(d), 32'h0);
    do_vec(model(16'h0E42, 3'b111));

    // Randomised transactions against the model
    for (int i = 0; i < 6; i++) begin
      logic [15:0] rc;
      logic [2:0]  ra;
      rc = 16'($urandom);
      ra = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b111;
      do_vec(model(rc, ra));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
